// File: rtl/disp_band_sequencer_if.sv
// Pixel-pair input stream and column-tagged disparity output stream of disp_band_sequencer.
// disp_err is present only when SEQ_WATCHDOG_EN is defined.
interface disp_band_sequencer_if #(
  parameter int DATA_SIZE = 8,
  parameter int DISP_BITS = 6,
  parameter int COL_BITS  = 6
);
  logic                 pix_valid;
  logic                 pix_ready;
  logic [DATA_SIZE-1:0] pix_L;
  logic [DATA_SIZE-1:0] pix_R;
  logic                 disp_valid;
  logic                 disp_ready;
  logic [DISP_BITS-1:0] disp_out;
  logic [COL_BITS-1:0]  disp_col;
`ifdef SEQ_WATCHDOG_EN
  logic                 disp_err;

  // master: pixel source and result sink; slave: the sequencer
  modport master (output pix_valid, pix_L, pix_R, disp_ready,
                  input  pix_ready, disp_valid, disp_out, disp_col, disp_err);
  modport slave  (input  pix_valid, pix_L, pix_R, disp_ready,
                  output pix_ready, disp_valid, disp_out, disp_col, disp_err);
`else
  modport master (output pix_valid, pix_L, pix_R, disp_ready,
                  input  pix_ready, disp_valid, disp_out, disp_col);
  modport slave  (input  pix_valid, pix_L, pix_R, disp_ready,
                  output pix_ready, disp_valid, disp_out, disp_col);
`endif
endinterface

// File: rtl/disp_band_sequencer.sv
// Band assembler and column sweeper feeding the compute_max_disp engine.
// Optional WAIT-state watchdog with disp_err output: define SEQ_WATCHDOG_EN.
module disp_band_sequencer #(
  parameter int WIN       = 15,
  parameter int DATA_SIZE = 8,
  parameter int IMG_W     = 64,
  parameter int MAX_DISP  = 64,
  parameter int DISP_BITS = $clog2(MAX_DISP),
  parameter int COL_BITS  = $clog2(IMG_W)
`ifdef SEQ_WATCHDOG_EN
  ,
  parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  disp_band_sequencer_if.slave           io,
  output logic [DATA_SIZE*IMG_W*WIN-1:0] band_L,
  output logic [DATA_SIZE*IMG_W*WIN-1:0] band_R,
  output logic                           eng_start,
  output logic [COL_BITS-1:0]            eng_col,
  output logic                           eng_clr,
  input  logic                           eng_done,
  input  logic [DISP_BITS-1:0]           eng_disp,
  output logic                           busy
);

  localparam int BAND_W = DATA_SIZE * IMG_W * WIN;
  localparam int NPIX   = WIN * IMG_W;
  localparam int CNT_W  = $clog2(NPIX);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(NPIX - 1);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(IMG_W - WIN);

  typedef enum logic [2:0] {
    S_FILL,
    S_START,
    S_WAIT,
    S_EMIT,
    S_CLEAR
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    pix_cnt;
  logic [COL_BITS-1:0] col;
  logic [BAND_W-1:0]   band_l_q, band_r_q;
  logic [DISP_BITS-1:0] res_disp_p0;
  logic [COL_BITS-1:0]  res_col_p0;

  logic pix_ready_c, pix_acc, take_res, timeout, start_c, clr_c, vld_c, busy_c;

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            res_err_p0;

  assign timeout = (state == S_WAIT) && !eng_done && (wd_cnt == WD_LAST);

  // Cleared in START so every WAIT visit gets the full budget.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if (state == S_START) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign pix_acc  = io.pix_valid && pix_ready_c;
  assign take_res = (state == S_WAIT) && eng_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pix_ready_c = 1'b0;
    start_c     = 1'b0;
    clr_c       = 1'b0;
    vld_c       = 1'b0;
    busy_c      = 1'b1;
    case (state)
      S_FILL: begin
        busy_c      = 1'b0;
        pix_ready_c = rst;
        if (pix_acc && (pix_cnt == CNT_LAST)) state_nxt = S_START;
      end
      S_START: begin
        start_c   = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done || timeout) state_nxt = S_EMIT;
      end
      S_EMIT: begin
        vld_c = 1'b1;
        if (io.disp_ready) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        clr_c     = 1'b1;
        state_nxt = (col == COL_LAST) ? S_FILL : S_START;
      end
      default: state_nxt = S_FILL;
    endcase
  end

  // Band capture and column sweep
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt  <= '0;
      col      <= '0;
      band_l_q <= '0;
      band_r_q <= '0;
    end else begin
      if (pix_acc) begin
        band_l_q[int'(pix_cnt)*DATA_SIZE +: DATA_SIZE] <= io.pix_L;
        band_r_q[int'(pix_cnt)*DATA_SIZE +: DATA_SIZE] <= io.pix_R;
        if (pix_cnt == CNT_LAST) begin
          pix_cnt <= '0;
          col     <= '0;
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end
      if (state == S_CLEAR) begin
        col <= (col == COL_LAST) ? '0 : col + 1'b1;
      end
    end
  end

  // Result stage p0: captured when WAIT ends, held through EMIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_disp_p0 <= '0;
      res_col_p0  <= '0;
`ifdef SEQ_WATCHDOG_EN
      res_err_p0  <= 1'b0;
`endif
    end else if (take_res) begin
      res_disp_p0 <= eng_disp;
      res_col_p0  <= col;
`ifdef SEQ_WATCHDOG_EN
      res_err_p0  <= 1'b0;
    end else if (timeout) begin
      res_disp_p0 <= '0;
      res_col_p0  <= col;
      res_err_p0  <= 1'b1;
`endif
    end
  end

  assign io.pix_ready  = pix_ready_c;
  assign io.disp_valid = vld_c;
  assign io.disp_out   = res_disp_p0;
  assign io.disp_col   = res_col_p0;
`ifdef SEQ_WATCHDOG_EN
  assign io.disp_err   = res_err_p0 && vld_c;
`endif
  assign band_L    = band_l_q;
  assign band_R    = band_r_q;
  assign eng_start = start_c;
  assign eng_col   = col;
  assign eng_clr   = clr_c;
  assign busy      = busy_c;

endmodule

// File: tb/tb_disp_band_sequencer.sv
// Directed bench for disp_band_sequencer with a stub engine answering col+1 five cycles after eng_start.
// Watchdog scenario is included when SEQ_WATCHDOG_EN is defined.
module tb_disp_band_sequencer;
  localparam int WIN = 3, DATA_SIZE = 8, IMG_W = 8, MAX_DISP = 8;
  localparam int DISP_BITS = 3, COL_BITS = 3;
  localparam int NPIX = WIN * IMG_W, NCOL = IMG_W - WIN + 1, BAND_W = DATA_SIZE * NPIX;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [BAND_W-1:0]    band_L, band_R;
  logic                 eng_start, eng_clr, eng_done, busy;
  logic [COL_BITS-1:0]  eng_col;
  logic [DISP_BITS-1:0] eng_disp;

  logic                 stub_en, stub_done, stray_done;
  logic [2:0]           stub_cnt;
  logic [COL_BITS-1:0]  stub_col;
  logic [DISP_BITS-1:0] stub_disp;

  int vectors = 0;
  int miscompares = 0;
  int n_start = 0;
  int n_clr = 0;
  int res_col[$];
  int res_out[$];
  int start_col[$];

  disp_band_sequencer_if #(.DATA_SIZE(DATA_SIZE), .DISP_BITS(DISP_BITS), .COL_BITS(COL_BITS)) io ();

  disp_band_sequencer #(
    .WIN(WIN), .DATA_SIZE(DATA_SIZE), .IMG_W(IMG_W), .MAX_DISP(MAX_DISP),
    .DISP_BITS(DISP_BITS), .COL_BITS(COL_BITS)
`ifdef SEQ_WATCHDOG_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk(clk), .rst(rst), .io(io),
    .band_L(band_L), .band_R(band_R),
    .eng_start(eng_start), .eng_col(eng_col), .eng_clr(eng_clr),
    .eng_done(eng_done), .eng_disp(eng_disp), .busy(busy)
  );

  always #5 clk = ~clk;

  assign eng_done = stub_done | stray_done;
  assign eng_disp = stray_done ? 3'd7 : stub_disp;

  // Stub engine shares the system reset
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      stub_done <= 1'b0; stub_cnt <= 3'd0; stub_col <= '0; stub_disp <= '0;
    end else begin
      stub_done <= 1'b0;
      if (eng_start && stub_en) begin
        stub_cnt <= 3'd5; stub_col <= eng_col;
      end else if (stub_cnt != 3'd0) begin
        stub_cnt <= stub_cnt - 3'd1;
        if (stub_cnt == 3'd1) begin stub_done <= 1'b1; stub_disp <= stub_col + 3'd1; end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (eng_start) begin n_start++; start_col.push_back(int'(eng_col)); end
      if (eng_clr) n_clr++;
      if (io.disp_valid && io.disp_ready) begin
        res_col.push_back(int'(io.disp_col)); res_out.push_back(int'(io.disp_out));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t exceeded the limit", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic stream_band(input int lo, input int ro);
    for (int k = 0; k < NPIX; k++) begin
      io.pix_valid = 1'b1; io.pix_L = 8'(k + lo); io.pix_R = 8'(k + ro);
      tick();
    end
    io.pix_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_start_col(input int c, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (eng_start && (int'(eng_col) == c)) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (io.disp_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; stub_en = 1'b1; stray_done = 1'b0;
    io.pix_valid = 1'b0; io.pix_L = '0; io.pix_R = '0; io.disp_ready = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (io.pix_ready !== 1'b0) begin miscompares++; $display("FAIL reset_pix_ready: got %b want 0", io.pix_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if ({eng_start, eng_clr} !== 2'b00) begin miscompares++; $display("FAIL reset_eng_pulses: got %b want 00", {eng_start, eng_clr}); end
    vectors++; if (eng_col !== 3'd0) begin miscompares++; $display("FAIL reset_eng_col: got %0d want 0", eng_col); end
    vectors++; if (io.disp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_disp_valid: got %b want 0", io.disp_valid); end
    vectors++; if ({io.disp_out, io.disp_col} !== 6'd0) begin miscompares++; $display("FAIL reset_disp_data: got out %0d col %0d want 0 0", io.disp_out, io.disp_col); end
    vectors++; if ((band_L !== '0) || (band_R !== '0)) begin miscompares++; $display("FAIL reset_band: got L %h R %h want 0", band_L, band_R); end
`ifdef SEQ_WATCHDOG_EN
    vectors++; if (io.disp_err !== 1'b0) begin miscompares++; $display("FAIL reset_disp_err: got %b want 0", io.disp_err); end
`endif
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    vectors++; if (io.pix_ready !== 1'b1) begin miscompares++; $display("FAIL fill_pix_ready: got %b want 1", io.pix_ready); end
  endtask

  task automatic test_fill_and_sweep();
    logic [BAND_W-1:0] exp_l, exp_r;
    int b_res, b_st, b_clr;
    bit ok;
    for (int k = 0; k < NPIX; k++) begin exp_l[k*8 +: 8] = 8'(k); exp_r[k*8 +: 8] = 8'(k + 100); end
    b_res = res_col.size(); b_st = n_start; b_clr = n_clr;
    io.disp_ready = 1'b1;
    stream_band(0, 100);
    @(negedge clk);
    vectors++; if (io.pix_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready_drop: got %b want 0", io.pix_ready); end
    vectors++; if (band_L !== exp_l) begin miscompares++; $display("FAIL fill_band_L: got %h want %h", band_L, exp_l); end
    vectors++; if (band_R !== exp_r) begin miscompares++; $display("FAIL fill_band_R: got %h want %h", band_R, exp_r); end
    vectors++; if ({eng_start, eng_col} !== 4'b1_000) begin miscompares++; $display("FAIL first_start: got start %b col %0d want 1 0", eng_start, eng_col); end
    wait_idle(200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL sweep_timeout: busy still %b want 0", busy); end
    tick(); tick();
    vectors++; if (res_col.size() - b_res != NCOL) begin miscompares++; $display("FAIL sweep_count: got %0d want %0d", res_col.size() - b_res, NCOL); end
    for (int i = 0; i < NCOL && b_res + i < res_col.size(); i++) begin
      vectors++;
      if ((res_col[b_res+i] != i) || (res_out[b_res+i] != i + 1)) begin
        miscompares++; $display("FAIL sweep_result%0d: got (%0d,%0d) want (%0d,%0d)", i, res_col[b_res+i], res_out[b_res+i], i, i + 1);
      end
    end
    vectors++; if ((n_start - b_st != NCOL) || (n_clr - b_clr != NCOL)) begin miscompares++; $display("FAIL sweep_pulses: got start %0d clr %0d want %0d each", n_start - b_st, n_clr - b_clr, NCOL); end
    for (int i = 0; i < NCOL && b_st + i < start_col.size(); i++) begin
      vectors++; if (start_col[b_st+i] != i) begin miscompares++; $display("FAIL start_col%0d: got %0d want %0d", i, start_col[b_st+i], i); end
    end
    @(negedge clk);
    vectors++; if ({io.pix_ready, busy} !== 2'b10) begin miscompares++; $display("FAIL back_to_fill: got ready %b busy %b want 1 0", io.pix_ready, busy); end
  endtask

  task automatic test_backpressure();
    int b_res, b_st, b_clr;
    bit ok;
    b_res = res_col.size();
    io.disp_ready = 1'b1;
    stream_band(50, 150);
    @(negedge clk);
    vectors++; if ((band_L[23*8 +: 8] !== 8'd73) || (band_R[0 +: 8] !== 8'd150)) begin miscompares++; $display("FAIL band2_bytes: got L23 %0d R0 %0d want 73 150", band_L[23*8 +: 8], band_R[0 +: 8]); end
    wait_start_col(2, 100, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL bp_reach_col2: start for column 2 not seen, got col %0d", eng_col); end
    tick(); io.disp_ready = 1'b0;
    wait_valid(50, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL bp_valid_timeout: disp_valid got %b want 1", io.disp_valid); end
    b_st = n_start; b_clr = n_clr;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if ({io.disp_valid, io.disp_out, io.disp_col, eng_start, eng_clr} !== {1'b1, 3'd3, 3'd2, 2'b00}) begin
        miscompares++; $display("FAIL bp_hold%0d: got valid %b out %0d col %0d start %b clr %b want 1 3 2 0 0", i, io.disp_valid, io.disp_out, io.disp_col, eng_start, eng_clr);
      end
`ifdef SEQ_WATCHDOG_EN
      vectors++; if (io.disp_err !== 1'b0) begin miscompares++; $display("FAIL bp_err%0d: got %b want 0", i, io.disp_err); end
`endif
    end
    tick(); io.disp_ready = 1'b1;
    wait_idle(200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL bp_idle_timeout: busy got %b want 0", busy); end
    tick(); tick();
    vectors++; if ((n_start - b_st != 3) || (n_clr - b_clr != 4)) begin miscompares++; $display("FAIL bp_pulses: got start %0d clr %0d want 3 4", n_start - b_st, n_clr - b_clr); end
    vectors++; if (res_col.size() - b_res != NCOL) begin miscompares++; $display("FAIL bp_count: got %0d want %0d", res_col.size() - b_res, NCOL); end
    for (int i = 0; i < NCOL && b_res + i < res_col.size(); i++) begin
      vectors++;
      if ((res_col[b_res+i] != i) || (res_out[b_res+i] != i + 1)) begin
        miscompares++; $display("FAIL bp_result%0d: got (%0d,%0d) want (%0d,%0d)", i, res_col[b_res+i], res_out[b_res+i], i, i + 1);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [BAND_W-1:0] exp_l;
    int b_res, b_clr;
    bit ok;
    io.disp_ready = 1'b1;
    stream_band(7, 77);
    wait_start_col(3, 100, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL mr_reach_col3: start for column 3 not seen, got col %0d", eng_col); end
    @(negedge clk);
    vectors++; if ({busy, io.disp_valid, eng_start, eng_clr} !== 4'b1000) begin miscompares++; $display("FAIL mr_in_wait: got busy %b valid %b start %b clr %b want 1 0 0 0", busy, io.disp_valid, eng_start, eng_clr); end
    b_res = res_col.size(); b_clr = n_clr;
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({io.pix_ready, busy, eng_start, eng_clr, io.disp_valid} !== 5'b0 || {eng_col, io.disp_out, io.disp_col} !== 9'd0) begin
      miscompares++; $display("FAIL mr_outputs: got ready %b busy %b start %b clr %b valid %b col %0d out %0d dcol %0d want all 0", io.pix_ready, busy, eng_start, eng_clr, io.disp_valid, eng_col, io.disp_out, io.disp_col);
    end
    vectors++; if ((band_L !== '0) || (band_R !== '0)) begin miscompares++; $display("FAIL mr_band: got L %h R %h want 0", band_L, band_R); end
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    repeat (10) @(negedge clk);
    vectors++; if ({io.pix_ready, busy} !== 2'b10) begin miscompares++; $display("FAIL mr_idle: got ready %b busy %b want 1 0", io.pix_ready, busy); end
    tick();
    vectors++; if ((res_col.size() != b_res) || (n_clr != b_clr)) begin miscompares++; $display("FAIL mr_no_emit: got %0d results %0d clr want %0d %0d", res_col.size(), n_clr, b_res, b_clr); end
    for (int k = 0; k < NPIX; k++) exp_l[k*8 +: 8] = 8'(k);
    stream_band(0, 100);
    @(negedge clk);
    vectors++; if ({eng_start, eng_col} !== 4'b1_000) begin miscompares++; $display("FAIL mr_restart: got start %b col %0d want 1 0", eng_start, eng_col); end
    vectors++; if (band_L !== exp_l) begin miscompares++; $display("FAIL mr_band_refill: got %h want %h", band_L, exp_l); end
    wait_idle(200, ok);
    tick(); tick();
    vectors++; if ((res_col.size() - b_res != NCOL) || (res_col[res_col.size()-1] != NCOL - 1)) begin miscompares++; $display("FAIL mr_resweep: got %0d results want %0d", res_col.size() - b_res, NCOL); end
  endtask

  task automatic test_stray_done();
    int b_res;
    bit ok;
    b_res = res_col.size();
    tick(); stray_done = 1'b1; tick(); stray_done = 1'b0;
    @(negedge clk);
    vectors++; if ({busy, io.pix_ready, io.disp_valid} !== 3'b010) begin miscompares++; $display("FAIL stray_fill: got busy %b ready %b valid %b want 0 1 0", busy, io.pix_ready, io.disp_valid); end
    io.disp_ready = 1'b1;
    stream_band(20, 120);
    wait_start_col(4, 100, ok);
    tick(); io.disp_ready = 1'b0;
    wait_valid(50, ok);
    vectors++; if (!ok || {io.disp_out, io.disp_col} !== {3'd5, 3'd4}) begin miscompares++; $display("FAIL stray_pre: got valid %b out %0d col %0d want 1 5 4", io.disp_valid, io.disp_out, io.disp_col); end
    tick(); stray_done = 1'b1; tick(); stray_done = 1'b0;
    @(negedge clk);
    vectors++; if ({io.disp_valid, io.disp_out, io.disp_col} !== {1'b1, 3'd5, 3'd4}) begin miscompares++; $display("FAIL stray_emit: got valid %b out %0d col %0d want 1 5 4", io.disp_valid, io.disp_out, io.disp_col); end
    tick(); io.disp_ready = 1'b1;
    wait_idle(200, ok);
    tick(); tick();
    vectors++; if (res_col.size() - b_res != NCOL) begin miscompares++; $display("FAIL stray_count: got %0d want %0d", res_col.size() - b_res, NCOL); end
    for (int i = 0; i < NCOL && b_res + i < res_col.size(); i++) begin
      vectors++;
      if ((res_col[b_res+i] != i) || (res_out[b_res+i] != i + 1)) begin
        miscompares++; $display("FAIL stray_result%0d: got (%0d,%0d) want (%0d,%0d)", i, res_col[b_res+i], res_out[b_res+i], i, i + 1);
      end
    end
  endtask

`ifdef SEQ_WATCHDOG_EN
  task automatic test_watchdog();
    int wcyc;
    bit ok;
    stub_en = 1'b0; io.disp_ready = 1'b1;
    stream_band(0, 100);
    @(negedge clk);
    vectors++; if ({eng_start, eng_col} !== 4'b1_000) begin miscompares++; $display("FAIL wd_start: got start %b col %0d want 1 0", eng_start, eng_col); end
    wcyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (io.disp_valid) break;
      wcyc++;
    end
    vectors++; if (wcyc != 16) begin miscompares++; $display("FAIL wd_wait_cycles: got %0d want 16", wcyc); end
    vectors++; if ({io.disp_valid, io.disp_out, io.disp_col, io.disp_err} !== {1'b1, 3'd0, 3'd0, 1'b1}) begin miscompares++; $display("FAIL wd_result: got valid %b out %0d col %0d err %b want 1 0 0 1", io.disp_valid, io.disp_out, io.disp_col, io.disp_err); end
    wait_start_col(1, 10, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wd_next_col: start for column 1 not seen, got col %0d", eng_col); end
    @(negedge clk);
    vectors++; if (io.disp_err !== 1'b0) begin miscompares++; $display("FAIL wd_err_low: got %b want 0", io.disp_err); end
    wait_idle(400, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wd_sweep_timeout: busy got %b want 0", busy); end
    stub_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_fill_and_sweep();
    test_backpressure();
    test_mid_reset();
    test_stray_done();
`ifdef SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/disp_band_sequencer.md
Name: disp_band_sequencer

Overview:
- Initiator/feeder for the `compute_max_disp` disparity engine.
- Accepts a raster stream of left/right pixel pairs and assembles one WIN-row band into the flattened L/R arrays the engine consumes.
- Sweeps `col_index` across the band, pulsing the engine's `input_ready` once per column, collecting `output_disp` on `done`, and clearing the engine between columns.
- Re-emits results as a valid/ready disparity stream tagged with the column number.

Parameters:
- WIN, 15, window height/width in pixels
- DATA_SIZE, 8, bits per pixel
- IMG_W, 64, band width in pixels
- MAX_DISP, 64, disparity range; DISP_BITS = clog2(MAX_DISP)
- COL_BITS, clog2(IMG_W), column index width
- TIMEOUT_CYC, 4096, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- pix_valid  in  1  pixel pair valid
- pix_ready  out  1  sequencer accepts a pixel pair
- pix_L  in  DATA_SIZE  left pixel
- pix_R  in  DATA_SIZE  right pixel
- band_L  out  DATA_SIZE*IMG_W*WIN  flattened left band, to engine input_array_L
- band_R  out  DATA_SIZE*IMG_W*WIN  flattened right band, to engine input_array_R
- eng_start  out  1  one-cycle pulse, to engine input_ready
- eng_col  out  COL_BITS  to engine col_index
- eng_clr  out  1  one-cycle engine clear pulse, to engine reset
- eng_done  in  1  engine done
- eng_disp  in  DISP_BITS  engine output_disp
- disp_valid  out  1  result valid
- disp_ready  in  1  downstream accepts result
- disp_out  out  DISP_BITS  disparity result
- disp_col  out  COL_BITS  column of disp_out
- busy  out  1  high in every state except FILL

Behaviour:
- Reset (rst=0, async):
  - state=FILL, pixel count=0, column=0.
  - band_L and band_R all zero.
  - pix_ready=0 while rst=0, then 1 in FILL.
  - eng_start=0, eng_clr=0, eng_col=0, disp_valid=0, disp_out=0, disp_col=0, busy=0.
- Band packing: accepted pixel k (k = row*IMG_W + col, row-major, k = 0..WIN*IMG_W-1) is written to band bits [k*DATA_SIZE +: DATA_SIZE].
- FILL:
  - pix_ready=1; a pixel is accepted on pix_valid&pix_ready; count increments.
  - When pixel WIN*IMG_W-1 is accepted: count returns to 0, column=0, next state START.
  - pix_ready is 0 in all other states; pix_valid is ignored there.
- START:
  - eng_start=1 for exactly one cycle; eng_col=column, held stable from START through CLEAR.
  - Next state WAIT.
- WAIT:
  - On eng_done=1: register eng_disp into disp_out, set disp_col=column, then go to EMIT.
  - disp_valid rises on the cycle after done is sampled.
  - eng_done outside WAIT is ignored.
- EMIT:
  - disp_valid=1 and disp_out/disp_col are held until disp_valid&disp_ready.
  - On handshake: disp_valid=0 next cycle, then go to CLEAR.
  - If disp_ready is already 1 on entry, the handshake completes in one cycle.
- CLEAR:
  - eng_clr=1 for one cycle.
  - If column == IMG_W-WIN, next state FILL (band contents kept until overwritten).
  - Otherwise column+1 and next state START.
- Per-column latency excluding engine time and backpressure: START(1) + done sample(1) + EMIT(1) + CLEAR(1) = 4 cycles.
- Columns emitted per band: IMG_W-WIN+1, in ascending order 0..IMG_W-WIN.
- Column counter arithmetic is unsigned COL_BITS and never wraps; the terminal value is IMG_W-WIN.
- A reset mid-sweep aborts immediately: no partial result is emitted, and the engine receives no eng_clr (it is expected to share the same system reset).

Optional Feature:
- Macro: SEQ_WATCHDOG_EN.
- With the macro defined:
  - A counter runs in WAIT and is cleared on entry to WAIT.
  - If TIMEOUT_CYC cycles pass without eng_done, go to EMIT with disp_out=0 and disp_err=1.
  - disp_err is an extra 1-bit output, valid alongside disp_valid, and 0 otherwise and at reset.
- Without the macro: no counter and no disp_err port; WAIT waits indefinitely.

Test Plan (WIN=3, IMG_W=8, MAX_DISP=8, stub engine asserting done 5 cycles after eng_start):
- Reset then stream 24 pixels with pix_L=k, pix_R=k+100 (k = 0..23) -> band_L byte k = k, band_R byte k = k+100; pix_ready drops the cycle after pixel 23 is accepted; eng_start pulses once with eng_col=0.
- Stub returns disp = col+1, disp_ready tied 1 -> 6 results with (disp_col, disp_out) = (0,1)…(5,6); each is followed by one eng_clr pulse; state returns to FILL and pix_ready=1.
- Hold disp_ready=0 for 10 cycles during column 2 -> disp_valid, disp_out=3 and disp_col=2 stay stable; no eng_start or eng_clr is issued until the handshake completes.
- Assert rst=0 during WAIT of column 3 -> all outputs are at reset values within the same cycle; a fresh 24-pixel band restarts the sweep at column 0.
- Pulse eng_done during FILL and during EMIT -> no state change and no extra results.
- SEQ_WATCHDOG_EN with TIMEOUT_CYC=16 and a stub that never returns done -> after 16 WAIT cycles disp_valid=1, disp_out=0, disp_err=1; the sweep continues to the next column.
